txn_rr_arbiter: RTL and testbench

//   Shares one downstream transaction port among NREQ requesters with round-robin fairness.

---
 rtl/txn_arb_pkg.sv | 42 ++++
 rtl/txn_rr_picker.sv | 29 ++
 rtl/txn_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_txn_rr_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/txn_arb_pkg.sv
// Shared types for the transaction round-robin arbiter: packet layout, FSM states
// and a behavioural round-robin pick helper for arbiters up to 16 requesters.
package txn_arb_pkg;

  localparam int TXN_AW = 16;
  localparam int TXN_DW = 32;

  typedef struct packed {
    logic              write;
    logic [TXN_AW-1:0] addr;
    logic [TXN_DW-1:0] wdata;
  } txn_pkt_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] at or above ptr, wrapping; lowest offset wins.
  function automatic rr_pick_t rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i < n) begin
        k = (int'(ptr) + i) % n;
        if (req[4'(k)]) begin
          r.found = 1'b1;
          r.idx   = 4'(k);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/txn_rr_picker.sv
// Combinational round-robin picker: rotate req so ptr lands at bit 0, take the
// lowest set bit, then rotate the index back into requester numbering.
module rr_picker #(
  parameter int  N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[IW'(i)] = req[IW'((i + int'(ptr)) % N)];
    end
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[IW'(i)]) off = IW'(i);
    end
    found = |req;
    idx   = IW'((32'(off) + 32'(ptr)) % N);
  end

endmodule

// File: rtl/txn_rr_arbiter.sv
// Round-robin arbiter owning one downstream transaction port; a grant is held
// from command issue until its response or timeout, so one transaction is in flight.
module txn_rr_arbiter
  import txn_arb_pkg::*;
#(
  parameter int  NREQ   = 4,
  parameter int  TO_CYC = 255,
  localparam int IW     = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  txn_pkt_t [NREQ-1:0]   req_pkt,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output txn_pkt_t              dn_pkt,
  input  logic                  dn_rsp_vld,
  input  logic [TXN_DW-1:0]     dn_rsp_data,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [TXN_DW-1:0]     rsp_data,
  output logic                  rsp_err,
  output logic [IW-1:0]         grant_id,
  output logic                  busy
);

  localparam int CW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     grant_q, grant_d;
  txn_pkt_t          pkt_q, pkt_d;
  logic              dn_valid_q, dn_valid_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [TXN_DW-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;
  logic [CW-1:0]     tmo_q, tmo_d;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     ptr_next;

  rr_picker #(.N(NREQ)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign ptr_next = IW'((32'(grant_q) + 32'd1) % NREQ);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    pkt_d       = pkt_q;
    dn_valid_d  = dn_valid_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    tmo_d       = tmo_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d               = pick_idx;
          pkt_d                 = req_pkt[pick_idx];
          req_ready_d[pick_idx] = 1'b1;
          dn_valid_d            = 1'b1;
          state_d               = ISSUE;
        end
      end
      ISSUE: begin
        if (dn_valid_q && dn_ready) begin
          dn_valid_d = 1'b0;
          tmo_d      = '0;
          state_d    = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // Counter includes the current cycle, so a response in the last allowed cycle still wins.
        tmo_d = (tmo_q == CW'(TO_CYC)) ? tmo_q : tmo_q + CW'(1);
        if (dn_rsp_vld) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_data_d           = dn_rsp_data;
          rsp_err_d            = 1'b0;
          rr_ptr_d             = ptr_next;
          state_d              = IDLE;
        end else if (TO_CYC != 0 && tmo_d == CW'(TO_CYC)) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_data_d           = '0;
          rsp_err_d            = 1'b1;
          rr_ptr_d             = ptr_next;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      pkt_q       <= '0;
      dn_valid_q  <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      pkt_q       <= pkt_d;
      dn_valid_q  <= dn_valid_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_d;
    end
  end

  assign req_ready = req_ready_q;
  assign dn_valid  = dn_valid_q;
  assign dn_pkt    = pkt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_txn_rr_arbiter.sv
// Bench for txn_rr_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_txn_rr_arbiter;
  import txn_arb_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  txn_pkt_t [N-1:0] req_pkt = '0;
  logic            dn_valid;
  logic            dn_ready = 1'b0;
  txn_pkt_t        dn_pkt;
  logic            dn_rsp_vld = 1'b0;
  logic [31:0]     dn_rsp_data = '0;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic [IW-1:0]   grant_id;
  logic            busy;

  txn_rr_arbiter #(.NREQ(N), .TO_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_pkt     (req_pkt),
    .dn_valid    (dn_valid),
    .dn_ready    (dn_ready),
    .dn_pkt      (dn_pkt),
    .dn_rsp_vld  (dn_rsp_vld),
    .dn_rsp_data (dn_rsp_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one outstanding transaction, phase 0 = free, 1 = command offered, 2 = awaiting response.
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_grant = 0;
  int          m_wait  = 0;
  logic        e_dn_valid = 1'b0;
  logic [N-1:0] e_req_ready = '0;
  logic [N-1:0] e_rsp_valid = '0;
  logic [31:0] e_rsp_data = '0;
  logic        e_rsp_err = 1'b0;
  txn_pkt_t    e_pkt = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string nm, input int cyc);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no event within %0d cycles at %0t", nm, cyc, $time);
  endtask

  task automatic model_step();
    int  j;
    logic hit;
    e_req_ready = '0;
    e_rsp_valid = '0;
    if (rst) begin
      m_phase    = 0;
      m_ptr      = 0;
      m_grant    = 0;
      e_dn_valid = 1'b0;
      e_rsp_data = '0;
      e_rsp_err  = 1'b0;
      e_pkt      = '0;
    end else if (m_phase == 0) begin
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!hit && req_valid[IW'(j)]) begin
          hit     = 1'b1;
          m_grant = j;
        end
      end
      if (hit) begin
        e_pkt       = req_pkt[IW'(m_grant)];
        e_req_ready = N'(1 << m_grant);
        e_dn_valid  = 1'b1;
        m_phase     = 1;
      end
    end else if (m_phase == 1) begin
      if (dn_ready) begin
        e_dn_valid = 1'b0;
        m_wait     = 0;
        m_phase    = 2;
      end
    end else begin
      m_wait++;
      if (dn_rsp_vld || m_wait == TO) begin
        e_rsp_valid = N'(1 << m_grant);
        e_rsp_data  = dn_rsp_vld ? dn_rsp_data : 32'h0;
        e_rsp_err   = !dn_rsp_vld;
        m_ptr       = (m_grant + 1) % N;
        m_phase     = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("dn_valid",  64'(dn_valid),  64'(e_dn_valid));
    chk("req_ready", 64'(req_ready), 64'(e_req_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
    chk("busy",      64'(busy),      64'(m_phase != 0));
    chk("grant_id",  64'(grant_id),  64'(m_grant));
    chk("dn_pkt",    64'(dn_pkt),    64'(e_pkt));
    if (e_rsp_valid != '0) begin
      chk("rsp_data", 64'(rsp_data), 64'(e_rsp_data));
      chk("rsp_err",  64'(rsp_err),  64'(e_rsp_err));
    end
    chk("onehot", 64'($onehot0(req_ready) && $onehot0(rsp_valid)), 64'(1));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_grant(output int g, input int maxc);
    g = -1;
    for (int i = 0; i < maxc && g < 0; i++) begin
      tick();
      if (req_ready != '0) g = int'(grant_id);
    end
    if (g < 0) fail_bound("wait_grant", maxc);
  endtask

  task automatic wait_idle(input int maxc);
    logic done;
    done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      tick();
      if (!busy) done = 1'b1;
    end
    if (!done) fail_bound("wait_idle", maxc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int       g;
    int       exp_t1 [6] = '{0, 1, 2, 3, 0, 1};
    txn_pkt_t p;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_dn_valid",  64'(dn_valid),  64'(0));
    chk("rst_grant_id",  64'(grant_id),  64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    rst = 1'b0;

    // T1: all requesting, immediate ready and response
    for (int i = 0; i < N; i++) begin
      req_pkt[i].write = 1'b0;
      req_pkt[i].addr  = 16'(16'h0100 + i);
      req_pkt[i].wdata = 32'(32'hC0DE0000 + i);
    end
    dn_ready    = 1'b1;
    dn_rsp_vld  = 1'b1;
    dn_rsp_data = 32'hA5A50001;
    req_valid   = '1;
    for (int i = 0; i < 6; i++) begin
      wait_grant(g, 10);
      chk("t1_grant_order", 64'(g), 64'(exp_t1[i]));
    end
    req_valid = '0;
    wait_idle(10);

    // T2: rr_ptr=2, only requester 1 valid, then all valid
    req_valid = 4'b0010;
    wait_grant(g, 5);
    chk("t2_single_req", 64'(g), 64'(1));
    req_valid = '0;
    wait_idle(10);
    req_valid = '1;
    wait_grant(g, 5);
    chk("t2_next_after_ptr", 64'(g), 64'(2));
    req_valid = '0;
    wait_idle(10);

    // T3: downstream stalls for 5 cycles; requester drops valid after grant
    dn_rsp_vld = 1'b0;
    dn_ready   = 1'b0;
    p.write = 1'b1;
    p.addr  = 16'h0044;
    p.wdata = 32'h0BADF00D;
    req_pkt[0] = p;
    req_valid  = 4'b0001;
    wait_grant(g, 5);
    chk("t3_grant", 64'(g), 64'(0));
    req_valid = '0;
    chk("t3_dn_valid_c1", 64'(dn_valid), 64'(1));
    chk("t3_dn_pkt_c1",   64'(dn_pkt),   64'(p));
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk("t3_dn_valid_hold", 64'(dn_valid), 64'(1));
      chk("t3_dn_pkt_hold",   64'(dn_pkt),   64'(p));
    end
    dn_ready = 1'b1;
    tick();
    dn_ready = 1'b0;
    chk("t3_accepted_once", 64'(dn_valid), 64'(0));
    chk("t3_busy_wait",     64'(busy),     64'(1));
    dn_rsp_vld  = 1'b1;
    dn_rsp_data = 32'h00000001;
    tick();
    dn_rsp_vld = 1'b0;
    chk("t3_write_ack", 64'(rsp_valid), 64'(4'b0001));

    // T6: read of 0x0010 returns 0xDEADBEEF one cycle after the response strobe
    p.write = 1'b0;
    p.addr  = 16'h0010;
    p.wdata = 32'h0;
    req_pkt[2] = p;
    req_valid  = 4'b0100;
    wait_grant(g, 5);
    chk("t6_grant", 64'(g), 64'(2));
    req_valid = '0;
    chk("t6_dn_pkt", 64'(dn_pkt), 64'(p));
    dn_ready = 1'b1;
    tick();
    dn_ready = 1'b0;
    tick();
    chk("t6_no_early_rsp", 64'(rsp_valid), 64'(0));
    dn_rsp_vld  = 1'b1;
    dn_rsp_data = 32'hDEADBEEF;
    tick();
    dn_rsp_vld = 1'b0;
    chk("t6_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    chk("t6_rsp_data",  64'(rsp_data),  64'(32'hDEADBEEF));
    chk("t6_rsp_err",   64'(rsp_err),   64'(0));

    // T4: timeout after 8 waiting cycles, later stray response ignored
    req_valid = 4'b1000;
    wait_grant(g, 5);
    chk("t4_grant", 64'(g), 64'(3));
    req_valid = '0;
    dn_ready  = 1'b1;
    tick();
    dn_ready = 1'b0;
    for (int c = 0; c < TO - 1; c++) tick();
    chk("t4_not_yet", 64'(rsp_valid), 64'(0));
    tick();
    chk("t4_rsp_valid", 64'(rsp_valid), 64'(4'b1000));
    chk("t4_rsp_err",   64'(rsp_err),   64'(1));
    chk("t4_rsp_data",  64'(rsp_data),  64'(0));
    chk("t4_idle",      64'(busy),      64'(0));
    dn_rsp_vld  = 1'b1;
    dn_rsp_data = 32'h5757AAAA;
    tick();
    dn_rsp_vld = 1'b0;
    chk("t4_stray_ignored", 64'(rsp_valid), 64'(0));

    // Response arriving in the cycle the counter reaches the limit wins
    req_valid = 4'b0001;
    wait_grant(g, 5);
    chk("tb_grant_wrap", 64'(g), 64'(0));
    req_valid = '0;
    dn_ready  = 1'b1;
    tick();
    dn_ready = 1'b0;
    for (int c = 0; c < TO - 1; c++) tick();
    dn_rsp_vld  = 1'b1;
    dn_rsp_data = 32'h600D0008;
    tick();
    dn_rsp_vld = 1'b0;
    chk("tb_race_valid", 64'(rsp_valid), 64'(4'b0001));
    chk("tb_race_err",   64'(rsp_err),   64'(0));
    chk("tb_race_data",  64'(rsp_data),  64'(32'h600D0008));

    // T5: reset while waiting for a response
    req_valid = 4'b0100;
    wait_grant(g, 5);
    chk("t5_grant", 64'(g), 64'(2));
    req_valid = '0;
    dn_ready  = 1'b1;
    tick();
    dn_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("t5_busy",      64'(busy),      64'(0));
    chk("t5_dn_valid",  64'(dn_valid),  64'(0));
    chk("t5_rsp_valid", 64'(rsp_valid), 64'(0));
    rst         = 1'b0;
    dn_rsp_vld  = 1'b1;
    dn_rsp_data = 32'h11112222;
    tick();
    dn_rsp_vld = 1'b0;
    chk("t5_rsp_discarded", 64'(rsp_valid), 64'(0));
    req_valid = '1;
    wait_grant(g, 5);
    chk("t5_ptr_reset", 64'(g), 64'(0));
    req_valid  = '0;
    dn_ready   = 1'b1;
    dn_rsp_vld = 1'b1;
    wait_idle(10);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      req_valid = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req_valid = '0;
      for (int i = 0; i < N; i++) begin
        req_pkt[i].write = 1'($urandom);
        req_pkt[i].addr  = 16'($urandom);
        req_pkt[i].wdata = $urandom;
      end
      dn_ready    = ($urandom_range(0, 1) == 1);
      dn_rsp_vld  = ($urandom_range(0, 5) == 0);
      dn_rsp_data = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
